// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared types and the parity helper for uart_core
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    function automatic logic parity_bit(input logic data_xor, input parity_e mode);
        return data_xor ^ (mode == PARITY_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_bit_timer : down-counter pacing one serial bit; tick marks count zero
// Revision       : 1.0
// ----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_full,
    input  logic load_half,
    output logic tick
);
    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_full) begin
            cnt_d = FULL;
        end else if (load_half) begin
            cnt_d = HALF;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_core : parametrised full-duplex UART; UART_LOOPBACK_EN adds loopback
// Revision  : 1.0
// ----------------------------------------------------------------------------
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_tx,
    input  logic                 serial_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 loopback
);
    localparam int               IDX_W    = $clog2(DATA_BITS);
    localparam parity_e          PAR_MODE = parity_e'(PARITY[1:0]);
    localparam logic             PAR_EN   = (PAR_MODE != PARITY_NONE);
    localparam logic             TWO_STOP = (STOP_BITS == 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [IDX_W-1:0]     tx_idx_q, tx_idx_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_stop2_q, tx_stop2_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_tick, tx_load;

    assign tx_ready = (tx_state_q == TX_IDLE);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        tx_par_d   = tx_par_q;
        tx_stop2_d = tx_stop2_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data;
                    tx_idx_d   = '0;
                    tx_par_d   = parity_bit(^tx_data, PAR_MODE);
                    tx_stop2_d = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_load    = 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                    tx_idx_d   = tx_idx_q + IDX_W'(1);
                    if (tx_idx_q == LAST_IDX) begin
                        if (PAR_EN) tx_state_d = TX_PARITY;
                        else        tx_state_d = TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_load    = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_load = 1'b1;
                    if (TWO_STOP && !tx_stop2_q) tx_stop2_d = 1'b1;
                    else                         tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_shift_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
            tx_par_q   <= tx_par_d;
            tx_stop2_q <= tx_stop2_d;
            tx_line_q  <= tx_line_d;
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_full (tx_load),
        .load_half (1'b0),
        .tick      (tx_tick)
    );

    // ---------------- pin / loopback routing ----------------
    logic rx_in;

`ifdef UART_LOOPBACK_EN
    assign serial_tx = tx_line_q | loopback;
    assign rx_in     = loopback ? tx_line_q : serial_rx;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign serial_tx       = tx_line_q;
    assign rx_in           = serial_rx;
`endif

    // ---------------- receiver ----------------
    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [IDX_W-1:0]     rx_idx_q, rx_idx_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_tick, rx_load_full, rx_load_half, rx_done;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_handshake;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_shift_d   = rx_shift_q;
        rx_idx_d     = rx_idx_q;
        rx_par_d     = rx_par_q;
        rx_load_full = 1'b0;
        rx_load_half = 1'b0;
        rx_done      = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                // IDLE is only entered with the line high, so low here is a falling edge
                if (!rx_sync_q) begin
                    rx_state_d   = RX_START;
                    rx_load_half = 1'b1;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d   = RX_DATA;
                        rx_idx_d     = '0;
                        rx_load_full = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_load_full = 1'b1;
                    rx_shift_d   = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_idx_d     = rx_idx_q + IDX_W'(1);
                    if (rx_idx_q == LAST_IDX) begin
                        if (PAR_EN) rx_state_d = RX_PARITY;
                        else        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_d     = rx_sync_q;
                    rx_state_d   = RX_STOP;
                    rx_load_full = 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    rx_done    = 1'b1;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_handshake = rx_valid_q && rx_ready;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_perr_d  = rx_perr_q;
        rx_ovr_d   = rx_ovr_q;
        if (rx_handshake) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (rx_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_shift_q;
                rx_ferr_d  = !rx_sync_q;
                rx_perr_d  = PAR_EN && (rx_par_q != parity_bit(^rx_shift_q, PAR_MODE));
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_perr_q  <= rx_perr_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_full (rx_load_full),
        .load_half (rx_load_half),
        .tick      (rx_tick)
    );

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_overrun    = rx_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_core : self-checking bench for uart_core (even parity, two stop bits)
// Revision     : 1.0
// ----------------------------------------------------------------------------
module tb_uart_core;
    localparam int CPB        = 16;
    localparam int DB         = 8;
    localparam int PAR        = 1;
    localparam int SB         = 2;
    localparam int FRAME_BITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FRAME_CYC  = CPB * FRAME_BITS;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          serial_tx;
    logic          serial_rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_overrun;
    logic          loopback;
    logic          rx_drive;
    logic          ext_loop;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    assign serial_rx = ext_loop ? serial_tx : rx_drive;

    uart_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .PARITY       (PAR),
        .STOP_BITS    (SB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .serial_tx     (serial_tx),
        .serial_rx     (serial_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun),
        .loopback      (loopback)
    );

    // Reference frame: element i is the line level during bit period i
    function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [DB-1:0] w, input logic flip);
        logic [FRAME_BITS-1:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < DB; i++) begin
            f[1 + i] = w[i];
            ones += int'(w[i]);
        end
        if (PAR == 1) f[1 + DB] = ((ones % 2) == 1) ^ flip;
        if (PAR == 2) f[1 + DB] = ((ones % 2) == 0) ^ flip;
        return f;
    endfunction

    task automatic drive_frame(input logic [FRAME_BITS-1:0] f);
        for (int b = 0; b < FRAME_BITS; b++) begin
            rx_drive = f[b];
            repeat (CPB) @(negedge clock);
        end
        rx_drive = 1'b1;
    endtask

    task automatic wait_rx(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clock);
            if (rx_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 2 * FRAME_CYC && tx_ready !== 1'b1; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_ready = 1'b0;
        rx_drive = 1'b1;
        ext_loop = 1'b0;
        loopback = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({serial_tx, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun} !== {2'b11, 1'b0, 8'h00, 3'b000})
            $display("FAIL reset_held: got tx=%b rdy=%b vld=%b data=%h fe=%b pe=%b ov=%b, expected 1 1 0 00 0 0 0",
                     serial_tx, tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
        else n_pass++;
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if ({serial_tx, tx_ready, rx_valid, rx_overrun} !== 4'b1100)
            $display("FAIL reset_release: got tx=%b rdy=%b vld=%b ov=%b, expected 1 1 0 0",
                     serial_tx, tx_ready, rx_valid, rx_overrun);
        else n_pass++;
    endtask

    task automatic test_tx_frame(input logic [DB-1:0] w);
        logic [FRAME_BITS-1:0] f;
        int bad_bits;
        int bad_ready;
        f = frame_bits(w, 1'b0);
        wait_tx_idle();
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid  = 1'b0;
        bad_bits  = 0;
        bad_ready = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k > 0) @(negedge clock);
            if (serial_tx !== f[k / CPB]) bad_bits++;
            if (tx_ready !== 1'b0) bad_ready++;
        end
        n_checks++;
        if (bad_bits != 0 || bad_ready != 0)
            $display("FAIL tx_frame %h: got %0d wrong line cycles and %0d early-ready cycles, expected 0 and 0",
                     w, bad_bits, bad_ready);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({tx_ready, serial_tx} !== 2'b11)
            $display("FAIL tx_done %h: got ready=%b line=%b at cycle %0d, expected 1 1", w, tx_ready, serial_tx, FRAME_CYC);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DB-1:0] words [$];
        int guard;
        bit got;
        words.push_back(8'h3C);
        words.push_back(8'hFF);
        for (int i = 0; i < 3; i++) words.push_back(DB'($urandom));
        wait_tx_idle();
        ext_loop = 1'b1;
        fork
            begin
                foreach (words[i]) begin
                    tx_data  = words[i];
                    tx_valid = 1'b1;
                    guard    = 0;
                    while (tx_ready !== 1'b1 && guard < 2 * FRAME_CYC) begin
                        @(negedge clock);
                        guard++;
                    end
                    @(negedge clock);
                end
                tx_valid = 1'b0;
            end
            begin
                foreach (words[i]) begin
                    wait_rx(3 * FRAME_CYC, got);
                    n_checks++;
                    if (!got || {rx_data, rx_parity_err, rx_frame_err} !== {words[i], 2'b00})
                        $display("FAIL b2b_word[%0d]: got valid=%b data=%h pe=%b fe=%b, expected data=%h pe=0 fe=0",
                                 i, got, rx_data, rx_parity_err, rx_frame_err, words[i]);
                    else n_pass++;
                    consume();
                end
            end
        join
        wait_tx_idle();
        repeat (2) @(negedge clock);
        ext_loop = 1'b0;
    endtask

    task automatic test_rx_random();
        logic [DB-1:0] w;
        logic flip;
        bit got;
        for (int n = 0; n < 5; n++) begin
            w    = DB'($urandom);
            flip = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (n == 0) w = 8'h01;
            drive_frame(frame_bits(w, flip));
            wait_rx(2 * CPB, got);
            n_checks++;
            if (!got || {rx_data, rx_parity_err, rx_frame_err, rx_overrun} !== {w, flip, 2'b00})
                $display("FAIL rx_word[%0d]: got valid=%b data=%h pe=%b fe=%b ov=%b, expected data=%h pe=%b fe=0 ov=0",
                         n, got, rx_data, rx_parity_err, rx_frame_err, rx_overrun, w, flip);
            else n_pass++;
            consume();
            n_checks++;
            if (rx_valid !== 1'b0)
                $display("FAIL rx_clear[%0d]: got rx_valid=%b after handshake, expected 0", n, rx_valid);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        bit seen;
        bit got;
        rx_drive = 1'b0;
        repeat (5) @(negedge clock);
        rx_drive = 1'b1;
        seen = 1'b0;
        repeat (3 * CPB) begin
            @(negedge clock);
            if (rx_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL glitch: got rx_valid=1 after a 5-cycle pulse, expected 0");
        else n_pass++;
        drive_frame(frame_bits(8'h55, 1'b0));
        wait_rx(2 * CPB, got);
        n_checks++;
        if (!got || {rx_data, rx_parity_err, rx_frame_err} !== {8'h55, 2'b00})
            $display("FAIL after_glitch: got valid=%b data=%h pe=%b fe=%b, expected data=55 pe=0 fe=0",
                     got, rx_data, rx_parity_err, rx_frame_err);
        else n_pass++;
        consume();
    endtask

    task automatic test_overrun();
        drive_frame(frame_bits(8'h11, 1'b0));
        drive_frame(frame_bits(8'h22, 1'b0));
        repeat (2 * CPB) @(negedge clock);
        n_checks++;
        if ({rx_valid, rx_data, rx_overrun} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL overrun_hold: got valid=%b data=%h ov=%b, expected 1 11 1", rx_valid, rx_data, rx_overrun);
        else n_pass++;
        consume();
        n_checks++;
        if ({rx_valid, rx_overrun} !== 2'b00)
            $display("FAIL overrun_clear: got valid=%b ov=%b after handshake, expected 0 0", rx_valid, rx_overrun);
        else n_pass++;
    endtask

    task automatic test_break();
        logic [FRAME_BITS-1:0] f;
        logic [DB-1:0] w;
        bit seen;
        bit got;
        f = frame_bits(8'h00, 1'b0);
        f[FRAME_BITS-1 -: SB] = '0;
        drive_frame(f);
        rx_drive = 1'b0;
        repeat (40 - SB * CPB) @(negedge clock);
        n_checks++;
        if ({rx_valid, rx_data, rx_frame_err, rx_parity_err} !== {1'b1, 8'h00, 2'b10})
            $display("FAIL break_word: got valid=%b data=%h fe=%b pe=%b, expected 1 00 1 0",
                     rx_valid, rx_data, rx_frame_err, rx_parity_err);
        else n_pass++;
        consume();
        rx_drive = 1'b1;
        seen = 1'b0;
        repeat (FRAME_CYC + 2 * CPB) begin
            @(negedge clock);
            if (rx_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL break_restart: got a word while recovering from break, expected none");
        else n_pass++;
        w = DB'($urandom);
        drive_frame(frame_bits(w, 1'b0));
        wait_rx(2 * CPB, got);
        n_checks++;
        if (!got || {rx_data, rx_frame_err, rx_parity_err} !== {w, 2'b00})
            $display("FAIL after_break: got valid=%b data=%h fe=%b pe=%b, expected data=%h fe=0 pe=0",
                     got, rx_data, rx_frame_err, rx_parity_err, w);
        else n_pass++;
        consume();
    endtask

    task automatic test_loopback();
        logic [FRAME_BITS-1:0] f;
        int lows;
        int exp_lows;
        bit got;
        f        = frame_bits(8'h5A, 1'b0);
        exp_lows = 0;
        for (int b = 0; b < FRAME_BITS; b++) if (!f[b]) exp_lows += CPB;
        wait_tx_idle();
        loopback = 1'b1;
        lows     = 0;
        got      = 1'b0;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        for (int k = 0; k < FRAME_CYC + 2 * CPB; k++) begin
            if (serial_tx === 1'b0) lows++;
            if (rx_valid === 1'b1) got = 1'b1;
            @(negedge clock);
        end
`ifdef UART_LOOPBACK_EN
        n_checks++;
        if (lows != 0) $display("FAIL loopback_pin: got %0d low cycles on serial_tx, expected 0", lows);
        else n_pass++;
        n_checks++;
        if (!got || {rx_data, rx_parity_err, rx_frame_err} !== {8'h5A, 2'b00})
            $display("FAIL loopback_rx: got valid=%b data=%h pe=%b fe=%b, expected data=5a pe=0 fe=0",
                     got, rx_data, rx_parity_err, rx_frame_err);
        else n_pass++;
        if (got) consume();
`else
        n_checks++;
        if (lows != exp_lows) $display("FAIL loopback_ignored_pin: got %0d low cycles, expected %0d", lows, exp_lows);
        else n_pass++;
        n_checks++;
        if (got) $display("FAIL loopback_ignored_rx: got rx_valid=1, expected 0");
        else n_pass++;
`endif
        loopback = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [FRAME_BITS-1:0] f;
        bit bad;
        wait_tx_idle();
        tx_data  = DB'($urandom);
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        f = frame_bits(DB'($urandom), 1'b0);
        for (int b = 0; b < 5; b++) begin
            rx_drive = f[b];
            repeat (CPB) @(negedge clock);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({serial_tx, tx_ready, rx_valid} !== 3'b110)
            $display("FAIL reset_async: got tx=%b rdy=%b vld=%b before any clock edge, expected 1 1 0",
                     serial_tx, tx_ready, rx_valid);
        else n_pass++;
        rx_drive = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (FRAME_CYC + 4 * CPB) begin
            @(negedge clock);
            if (rx_valid !== 1'b0 || serial_tx !== 1'b1 || tx_ready !== 1'b1) bad = 1'b1;
        end
        n_checks++;
        if (bad || rx_data !== 8'h00)
            $display("FAIL reset_abort: got activity=%b data=%h after mid-frame reset, expected 0 00", bad, rx_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_tx_frame(8'hA5);
        for (int i = 0; i < 3; i++) test_tx_frame(DB'($urandom));
        test_back_to_back();
        test_rx_random();
        test_glitch();
        test_overrun();
        test_break();
        test_loopback();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
